// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int unsigned WordWidth = 32;
    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

    // IDLE may issue, WAIT expects a response to keep, DISCARD expects one to drop.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWait    = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO holding {pc+4, instr} pairs; head is read combinationally.
module fetch_queue_sync_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [Width-1:0]        wdata_i,
    output logic [Width-1:0]        rdata_o,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_pop;

    // Popping an empty queue is a no-op.
    assign do_pop  = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    // Pointer and occupancy update; clear overrides push and pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PtrW'(1);
            if (do_pop) rptr_d = rptr_q + PtrW'(1);
            if (push_i && !do_pop) begin
                count_d = count_q + (PtrW + 1)'(1);
            end else if (!push_i && do_pop) begin
                count_d = count_q - (PtrW + 1)'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write; no reset needed because the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
    end

    // Only one request is ever in flight and it is issued only with room left.
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(push_i && (count_q == (PtrW + 1)'(Depth))));
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: one outstanding imem request, results queued as {pc+4, instr}.
module fetch_queue #(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      WORD     = fetch_queue_pkg::WordWidth,
    parameter logic [WORD-1:0]  RESET_PC = WORD'(fetch_queue_pkg::ResetPcDefault)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [WORD-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [WORD-1:0]          imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [WORD-1:0]          imem_rdata,
    input  logic                     deq,
    output logic                     out_valid,
    output logic [WORD-1:0]          out_instr,
    output logic [WORD-1:0]          out_pcplus4,
    output logic [$clog2(DEPTH):0]   count
);

    import fetch_queue_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [WORD-1:0]   fetch_pc_q, fetch_pc_d;
    logic [WORD-1:0]   issued_pc_q, issued_pc_d;
    logic              push;
    logic              pop;
    logic              empty;
    logic              has_room;
    logic [2*WORD-1:0] head;
    logic [CntW-1:0]   fifo_count;
    logic              unused_redirect_lsbs;

    // Redirect targets are forced to word alignment.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign empty       = (fifo_count == '0);
    assign has_room    = (fifo_count < CntW'(DEPTH));
    assign pop         = deq && !empty && !redirect;
    assign imem_addr   = fetch_pc_q;
    assign out_valid   = !rst && !empty;
    assign out_instr   = out_valid ? head[WORD-1:0] : '0;
    assign out_pcplus4 = out_valid ? head[2*WORD-1:WORD] : '0;
    assign count       = fifo_count;

    // Request/response FSM plus redirect handling of the fetch PC.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        imem_req    = 1'b0;
        push        = 1'b0;
        case (state_q)
            StIdle: begin
                imem_req = !rst && !redirect && has_room;
                if (imem_req && imem_ready) begin
                    issued_pc_d = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + WORD'(4);
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    push    = !redirect;
                    state_d = StIdle;
                end else if (redirect) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (redirect) fetch_pc_d = {redirect_pc[WORD-1:2], 2'b00};
    end

    // FSM and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fetch_pc_q  <= {RESET_PC[WORD-1:2], 2'b00};
            issued_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
        end
    end

    fetch_queue_sync_fifo #(
        .Width (2 * WORD),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({issued_pc_q + WORD'(4), imem_rdata}),
        .rdata_o (head),
        .count_o (fifo_count)
    );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage that sits directly upstream of the IF/ID pipeline register.
- Replaces the combinational instruction-memory read with a request/response instruction-memory port that holds at most one request in flight.
- Buffers fetched instructions in a small FIFO as {pc+4, instr} pairs, so a stalled IF/ID does not block fetching.
- Accepts a redirect (taken branch or jump resolved in ID). A redirect flushes the queue and drops any stale in-flight response.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- WORD, 32, data and address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- redirect  in  1  taken branch or jump this cycle (ID_real_brc | ID_jump)
- redirect_pc  in  WORD  new fetch address, valid while redirect=1
- imem_req  out  1  request valid to instruction memory
- imem_addr  out  WORD  request address, word aligned
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  WORD  response instruction
- deq  in  1  consumer takes the head entry (IFID_write and not flushing)
- out_valid  out  1  head entry valid
- out_instr  out  WORD  head instruction
- out_pcplus4  out  WORD  head instruction address + 4
- count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset state: fetch_pc=RESET_PC, state=IDLE, read and write pointers=0, count=0.
- Outputs during and after reset: out_valid=0 and imem_req=0 while rst=1. out_instr and out_pcplus4 read 0 when the queue is empty after reset.
- State IDLE:
  - imem_req = !rst && !redirect && count<DEPTH; imem_addr=fetch_pc.
  - On imem_req && imem_ready: latch issued_pc=fetch_pc, set fetch_pc+=4, go to WAIT.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid && !redirect: push {issued_pc+4, imem_rdata} at the write pointer, then go to IDLE.
  - On redirect && !imem_rvalid: go to DISCARD.
  - On redirect && imem_rvalid: drop the response and go to IDLE.
- State DISCARD:
  - imem_req=0.
  - On imem_rvalid: drop the response and go to IDLE.
  - A redirect in DISCARD keeps the state and updates fetch_pc.
- Redirect (any state):
  - Next cycle: fetch_pc=redirect_pc, count=0, both pointers=0.
  - deq in the same cycle is ignored; flush wins.
  - A push in the same cycle is suppressed as specified above.
- Dequeue:
  - deq && out_valid && !redirect pops the head; the read pointer wraps modulo DEPTH.
  - deq while empty is ignored, with no underflow.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Overflow: impossible by construction, because a request is only issued when count<DEPTH and only one request is in flight. An assertion checks that no push occurs when count==DEPTH.
- Output timing: out_* reflect the head combinationally from registered storage. An entry pushed in cycle N is visible at out_valid in cycle N+1. Minimum fetch-to-output latency is 2 cycles when imem responds one cycle after acceptance.
- Address width: fetch_pc wraps modulo 2^32. imem_addr[1:0] is always 0; redirect_pc[1:0] is ignored and forced to 0.
- Reset mid-operation: a response arriving in the cycle after reset is dropped, because the state is IDLE.

Decomposition:
- Shared pipeline package:
  - WORD width constant.
  - RESET_PC default.
  - fetch-state enumeration: IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2.
- One natural sub-module: sync_fifo, parameterised by width (2*WORD) and DEPTH.
  - Inputs: push, pop, clear.
  - Outputs: head data, count.
- The FSM, PC register and redirect logic stay in fetch_queue.

Test Plan:
- Reset then streaming:
  - Stimulus: rst for 2 cycles, then imem_ready=1, with rvalid 1 cycle after each accept and rdata=addr^32'hA5A5_0000; deq=1 always.
  - Required: imem_addr sequence 0,4,8,…; out_pcplus4 sequence 4,8,12,…; out_instr matches the rdata for each address.
- Full queue:
  - Stimulus: deq=0, memory always ready.
  - Required: count reaches 4, after which imem_req stays 0. A single deq pulse produces exactly one new request, at address 16.
- Redirect while WAIT:
  - Stimulus: redirect=1, redirect_pc=32'h100 one cycle after an accept; rvalid with data 32'hDEAD arrives 3 cycles later.
  - Required: the DEAD word is never visible; count=0; the next imem_addr is 32'h100.
- Redirect coincident with rvalid and deq, queue holding 2 entries:
  - Required: the queue is empty next cycle, the response is dropped, and the state is IDLE with fetch_pc=redirect_pc.
- Unaligned redirect:
  - Stimulus: redirect_pc=32'h203.
  - Required: imem_addr=32'h200.
- Wrap at top of memory:
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required: the next request addresses are 32'hFFFF_FFFC then 32'h0, and out_pcplus4 for the first instruction is 32'h0.
